prio_enco_9x4: RTL and testbench
================================

PRIO_ENCO_9X4 -- requirements
Module: prio_enco_9x4

Interface
REQ-001 The block SHALL have one parameter, DEBOUNCE_CYCLES, default 4, giving the number of consecutive stable cycles needed to accept a key change; legal range 1..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all flops update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port enable, input, 1 bit: active-high keypad enable; while 0, no key load is issued.
REQ-005 The block SHALL have port d_in, input, 10 bits: asynchronous key lines; d_in[i]=1 means key i is pressed.
REQ-006 The block SHALL have port d_out, output, 4 bits: registered binary code of the accepted key, range 0..9.
REQ-007 The block SHALL have port loadn, output, 1 bit: registered, active-low, one-cycle load strobe qualifying d_out.

Function
REQ-008 d_in SHALL pass through a two-flop synchronizer (s1, s2) before any use.
REQ-009 Priority SHALL be highest index wins: d_out = index of the most significant set bit of the accepted key vector (d_in[9] highest, d_in[0] lowest).
REQ-010 "Key active" SHALL mean the accepted key vector is nonzero.
REQ-011 An armed flag SHALL be cleared whenever enable=0 or no key is active, and set after a load is issued.
REQ-012 When enable=1, a key is active and armed=0, the block SHALL drive loadn=0 for exactly one cycle and update d_out in the same cycle.
REQ-013 A key held with enable continuously 1 SHALL produce only one loadn pulse; no auto-repeat.
REQ-014 Deasserting enable and reasserting it while a key is still held SHALL produce a new loadn pulse with the current code.
REQ-015 A higher-priority key pressed while a lower one is held SHALL NOT produce a new pulse until all keys are released (armed stays 1).
REQ-016 d_out SHALL hold its last loaded value between pulses, while enable=0 and while no key is pressed.
REQ-017 Latency without debounce: d_in stable before edge k SHALL give loadn=0 and a valid d_out in the cycle after edge k+2.
REQ-018 enable SHALL be sampled unsynchronized at the output-register edge (it is a synchronous input).
REQ-019 loadn SHALL never be low for two consecutive cycles.

Reset
REQ-020 While reset=1 at a rising edge, the block SHALL set d_out=0, loadn=1, armed=0, synchronizer flops=0, debounce counter=0 and accepted vector=0.
REQ-021 Reset asserted during a loadn pulse SHALL return loadn to 1 at that edge.
REQ-022 After reset, a key already held SHALL be treated as a new press once it propagates through the synchronizer (and debounce, if compiled in).

Configuration
REQ-023 Macro PRIO_ENCO_DEBOUNCE_EN SHALL control debouncing.
REQ-024 With PRIO_ENCO_DEBOUNCE_EN defined, the accepted vector SHALL update only after s2 has held an identical value for DEBOUNCE_CYCLES consecutive edges; any change restarts the count.
REQ-025 With PRIO_ENCO_DEBOUNCE_EN defined, latency SHALL be 3+DEBOUNCE_CYCLES cycles.
REQ-026 Without PRIO_ENCO_DEBOUNCE_EN, the accepted vector SHALL equal s2 and the DEBOUNCE_CYCLES parameter SHALL be ignored.

Verification
REQ-027 One-hot sweep: for i=0..9, set d_in=1<<i and pulse enable 1->0->1 -> one loadn pulse per enable high phase with d_out=i.
REQ-028 Multi-key: d_in=10'b1000000101, enable=1 -> single pulse with d_out=9; then d_in=10'b0000000101 without release -> no pulse, d_out stays 9.
REQ-029 Hold: d_in=10'b0000001000 held for 50 cycles with enable=1 -> exactly one pulse, d_out=3.
REQ-030 Gating: enable=0 with d_in=10'b0000100000 -> loadn stays 1 and d_out keeps its previous value; raising enable -> pulse with d_out=5.
REQ-031 Reset: assert reset in the cycle loadn=0 -> next cycle loadn=1, d_out=0; key still held -> new pulse after latency.
REQ-032 Debounce (macro defined, DEBOUNCE_CYCLES=4): a 2-cycle glitch d_in=10'b0000000010 -> no pulse; a stable press -> pulse 7 cycles later with d_out=1.

Source files
------------

// File: rtl/prio_enco_9x4.sv
// Synchronized, optionally debounced 10-key priority encoder with a one-shot load strobe.
// Define PRIO_ENCO_DEBOUNCE_EN to filter key changes through a stability counter.
module prio_enco_9x4 #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [9:0] d_in,
  output logic [3:0] d_out,
  output logic       loadn
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES out of range 1..255");
  end

  logic [9:0] s1_q, s2_q;
  logic [9:0] acc;
  logic [3:0] enc;
  logic       key_act;

  logic [3:0] dout_q, dout_d;
  logic       loadn_q, loadn_d;
  logic       armed_q, armed_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_in;
      s2_q <= s1_q;
    end
  end

`ifdef PRIO_ENCO_DEBOUNCE_EN
  logic [9:0] cand_q, cand_d;
  logic [9:0] acc_q, acc_d;
  logic [7:0] cnt_q, cnt_d;

  // cnt_d is the number of consecutive edges s2 has shown cand_d,
  // including the current one.
  always_comb begin
    cand_d = cand_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = 8'd1;
    end else if (cnt_q != 8'hFF) begin
      cnt_d  = cnt_q + 8'd1;
    end
    if (cnt_d >= 8'(DEBOUNCE_CYCLES)) begin
      acc_d = s2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
    end
  end

  assign acc = acc_q;
`else
  assign acc = s2_q;
`endif

  assign key_act = |acc;

  always_comb begin
    enc = '0;
    for (int i = 0; i < 10; i++) begin
      if (acc[i]) enc = 4'(i);
    end
  end

  always_comb begin
    dout_d  = dout_q;
    loadn_d = 1'b1;
    armed_d = armed_q;
    if (!enable || !key_act) begin
      armed_d = 1'b0;
    end else if (!armed_q) begin
      dout_d  = enc;
      loadn_d = 1'b0;
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q  <= '0;
      loadn_q <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      loadn_q <= loadn_d;
      armed_q <= armed_d;
    end
  end

  assign d_out = dout_q;
  assign loadn = loadn_q;

endmodule

// File: tb/tb_prio_enco_9x4.sv
// Directed bench for prio_enco_9x4: latency, hold, sweep, multi-key,
// gating, reset-in-pulse and (with PRIO_ENCO_DEBOUNCE_EN) glitch rejection.
module tb_prio_enco_9x4;

`ifdef PRIO_ENCO_DEBOUNCE_EN
  localparam int LAT = 3 + 4;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [9:0] d_in;
  logic [3:0] d_out;
  logic       loadn;

  int n_chk  = 0;
  int n_fail = 0;
  int pulses = 0;
  int last_code = -1;
  int dbl = 0;
  logic prev_low = 1'b0;

  prio_enco_9x4 #(.DEBOUNCE_CYCLES(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .d_in   (d_in),
    .d_out  (d_out),
    .loadn  (loadn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (loadn === 1'b0) begin
      pulses++;
      last_code = int'(d_out);
      if (prev_low) dbl++;
      prev_low = 1'b1;
    end else begin
      prev_low = 1'b0;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    d_in   = '0;
    run(3);
    chk("rst_dout", int'(d_out), 0);
    chk("rst_loadn", int'(loadn), 1);
    reset = 1'b0;
    run(2);
    chk("idle_loadn", int'(loadn), 1);

    // latency and hold: key 3 for 50 cycles
    pulses = 0;
    enable = 1'b1;
    d_in   = 10'b0000001000;
    for (int c = 1; c < LAT; c++) begin
      tick();
      chk("lat_wait", int'(loadn), 1);
    end
    tick();
    chk("lat_loadn", int'(loadn), 0);
    chk("lat_code", int'(d_out), 3);
    run(50 - LAT);
    chk("hold_pulses", pulses, 1);
    chk("hold_dout", int'(d_out), 3);
    d_in = '0;
    run(LAT + 2);

    // one-hot sweep with enable toggling
    for (int i = 0; i < 10; i++) begin
      enable = 1'b0;
      d_in   = 10'd1 << i;
      run(LAT + 1);
      pulses = 0;
      enable = 1'b1;
      run(4);
      chk("sweep_p1", pulses, 1);
      chk("sweep_code", last_code, i);
      enable = 1'b0;
      run(2);
      enable = 1'b1;
      run(3);
      chk("sweep_p2", pulses, 2);
      chk("sweep_dout", int'(d_out), i);
    end

    // multi-key: 9 wins, later higher/lower changes do not re-fire
    enable = 1'b0;
    d_in   = '0;
    run(LAT + 2);
    pulses = 0;
    enable = 1'b1;
    d_in   = 10'b1000000101;
    run(LAT + 3);
    chk("multi_pulses", pulses, 1);
    chk("multi_code", last_code, 9);
    d_in = 10'b0000000101;
    run(LAT + 5);
    chk("multi_nopulse", pulses, 1);
    chk("multi_dout", int'(d_out), 9);

    // gating
    d_in = '0;
    run(LAT + 2);
    enable = 1'b0;
    d_in   = 10'b0000100000;
    pulses = 0;
    run(LAT + 5);
    chk("gate_pulses", pulses, 0);
    chk("gate_loadn", int'(loadn), 1);
    chk("gate_dout", int'(d_out), 9);
    enable = 1'b1;
    run(2);
    chk("gate_rise", pulses, 1);
    chk("gate_code", last_code, 5);

    // reset in the loadn=0 cycle, key still held
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    chk("rp_low", int'(loadn), 0);
    reset = 1'b1;
    tick();
    chk("rp_loadn", int'(loadn), 1);
    chk("rp_dout", int'(d_out), 0);
    reset  = 1'b0;
    pulses = 0;
    run(LAT - 1);
    chk("rp_wait", pulses, 0);
    tick();
    chk("rp_reload", int'(loadn), 0);
    chk("rp_code", int'(d_out), 5);

`ifdef PRIO_ENCO_DEBOUNCE_EN
    // glitch rejection then stable press
    d_in = '0;
    run(12);
    pulses = 0;
    d_in = 10'b0000000010;
    run(2);
    d_in = '0;
    run(12);
    chk("db_glitch", pulses, 0);
    d_in = 10'b0000000010;
    run(6);
    chk("db_wait", pulses, 0);
    tick();
    chk("db_loadn", int'(loadn), 0);
    chk("db_code", int'(d_out), 1);
`endif

    chk("no_double_low", dbl, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
